// File: rtl/lobby_audio_pkg.sv
// Shared types and default sizing for the lobby melody player.
// The sequencer state encoding lives here so the player and its bench agree on it.
package lobby_audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    PLAY
  } state_t;

  localparam int unsigned DEF_BEAT_CYCLES = 2500000;
  localparam int unsigned DEF_SONG_LEN    = 1000;
  localparam int unsigned DEF_ADDR_W      = 10;
  localparam int unsigned DEF_HP_W        = 19;

  localparam logic signed [31:0] DEF_AMPLITUDE = 32'sd10000000;

endpackage

// File: rtl/square_osc.sv
// Square-wave phase generator: toggles phase every half_period enabled cycles.
// A half_period of 0 is a rest; the counter freezes and rest is flagged.
module square_osc
  import lobby_audio_pkg::*;
#(
  parameter int unsigned HP_W = DEF_HP_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period,
  output logic            phase,
  output logic            rest
);

  logic [HP_W-1:0] count;

  assign rest = (half_period == '0);

  // clear starts every note on the positive half of the wave
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      phase <= 1'b0;
    end else if (clear) begin
      count <= '0;
      phase <= 1'b1;
    end else if (enable && !rest) begin
      if (count == half_period - HP_W'(1)) begin
        count <= '0;
        phase <= ~phase;
      end else begin
        count <= count + HP_W'(1);
      end
    end
  end

endmodule

// File: rtl/lobby_melody_player.sv
// Lobby music sequencer: walks an external note ROM at a fixed beat rate and
// feeds a +/-AMPLITUDE square wave straight into the audio controller FIFO.
module lobby_melody_player
  import lobby_audio_pkg::*;
#(
  parameter int unsigned       BEAT_CYCLES = DEF_BEAT_CYCLES,
  parameter int unsigned       SONG_LEN    = DEF_SONG_LEN,
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter int unsigned       HP_W        = DEF_HP_W,
  parameter logic signed [31:0] AMPLITUDE  = DEF_AMPLITUDE
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                play,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [HP_W-1:0]     rom_data,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic signed [31:0]  left_sample,
  output logic signed [31:0]  right_sample,
  output logic                playing,
  output logic                song_done
);

  localparam int unsigned       BEAT_W    = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  addr;
  logic [BEAT_W-1:0]  beat;
  logic [HP_W-1:0]    half_period;
  logic signed [31:0] sample;
  logic               halt;
  logic               beat_end;
  logic               osc_clear;
  logic               osc_enable;
  logic               phase;
  logic               rest;

  // Dropping play behaves exactly like reset, so both collapse into one clear
  assign halt     = reset | ~play;
  assign beat_end = (state == PLAY) && (beat == BEAT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!play) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_next = FETCH;
        FETCH:   state_next = WAIT;
        WAIT:    state_next = PLAY;
        PLAY:    state_next = beat_end ? FETCH : PLAY;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    playing         = (state == PLAY);
    write_audio_out = audio_out_allowed & (state == PLAY);
    song_done       = beat_end && (addr == ADDR_LAST) && !halt;
    osc_clear       = (state == WAIT);
    osc_enable      = (state == PLAY);
  end

  always_ff @(posedge CLOCK_50) begin
    if (halt) begin
      addr        <= '0;
      beat        <= '0;
      half_period <= '0;
      sample      <= '0;
    end else begin
      if (state == WAIT) begin
        half_period <= rom_data;
      end
      if (state == PLAY) begin
        if (beat_end) begin
          beat <= '0;
          addr <= (addr == ADDR_LAST) ? '0 : addr + ADDR_W'(1);
        end else begin
          beat <= beat + BEAT_W'(1);
        end
      end
      if ((state == PLAY) && !rest) begin
        sample <= phase ? AMPLITUDE : -AMPLITUDE;
      end else begin
        sample <= '0;
      end
    end
  end

  square_osc #(
    .HP_W (HP_W)
  ) u_osc (
    .clk         (CLOCK_50),
    .reset       (halt),
    .clear       (osc_clear),
    .enable      (osc_enable),
    .half_period (half_period),
    .phase       (phase),
    .rest        (rest)
  );

  assign rom_addr     = addr;
  assign left_sample  = sample;
  assign right_sample = sample;

endmodule

// File: tb/tb_lobby_melody_player.sv
// Scoreboard bench for lobby_melody_player with an 8-cycle beat and a 4-note song.
module tb_lobby_melody_player;

  localparam int BEAT = 8;
  localparam int SONG = 4;
  localparam int AMP  = 10000000;

  logic               clk;
  logic               reset;
  logic               play;
  logic [9:0]         rom_addr;
  logic [18:0]        rom_data;
  logic               allowed;
  logic               write_audio_out;
  logic signed [31:0] left_sample;
  logic signed [31:0] right_sample;
  logic               playing;
  logic               song_done;

  int rom [SONG] = '{3, 0, 1, 5};

  typedef struct {
    logic [9:0]         addr;
    logic               wr;
    logic signed [31:0] smp;
    logic               ply;
    logic               done;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_fail   = 0;

  int m_st   = 0;
  int m_addr = 0;
  int m_beat = 0;
  int m_hp   = 0;
  int m_smp  = 0;

  lobby_melody_player #(
    .BEAT_CYCLES (BEAT),
    .SONG_LEN    (SONG)
  ) dut (
    .CLOCK_50          (clk),
    .reset             (reset),
    .play              (play),
    .rom_addr          (rom_addr),
    .rom_data          (rom_data),
    .audio_out_allowed (allowed),
    .write_audio_out   (write_audio_out),
    .left_sample       (left_sample),
    .right_sample      (right_sample),
    .playing           (playing),
    .song_done         (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= 19'(rom[rom_addr[1:0]]);

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, want);
    end
  endtask

  // Reference: tone phase derived from position within the note, sample lags one cycle
  task automatic model_step();
    if (reset || !play) begin
      m_st = 0; m_addr = 0; m_beat = 0; m_smp = 0;
    end else begin
      if (m_st == 3 && m_hp != 0)
        m_smp = (((m_beat / m_hp) % 2) == 0) ? AMP : -AMP;
      else
        m_smp = 0;
      case (m_st)
        0: m_st = 1;
        1: m_st = 2;
        2: begin m_hp = rom[m_addr]; m_beat = 0; m_st = 3; end
        default: begin
          if (m_beat == BEAT - 1) begin
            m_beat = 0;
            m_addr = (m_addr + 1) % SONG;
            m_st   = 1;
          end else begin
            m_beat++;
          end
        end
      endcase
    end
  endtask

  task automatic push_expected();
    exp_t x;
    x.addr = 10'(m_addr);
    x.wr   = allowed && (m_st == 3);
    x.smp  = m_smp;
    x.ply  = (m_st == 3);
    x.done = (m_st == 3) && (m_beat == BEAT - 1) && (m_addr == SONG - 1) && play && !reset;
    sb.push_back(x);
  endtask

  // mode: 0 = allowed low, 1 = allowed high, 2 = random per cycle
  task automatic run(input int n, input logic p, input logic r, input int mode);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      play    = p;
      reset   = r;
      allowed = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      push_expected();
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rom_addr", rom_addr, e.addr);
      check("write_audio_out", write_audio_out, e.wr);
      check("left_sample", left_sample, e.smp);
      check("right_sample", right_sample, e.smp);
      check("playing", playing, e.ply);
      check("song_done", song_done, e.done);
    end
  end

  initial begin
    reset   = 1'b1;
    play    = 1'b0;
    allowed = 1'b0;
    repeat (2) @(posedge clk);
    run(2, 1'b0, 1'b1, 1);    // reset values
    run(45, 1'b1, 1'b0, 1);   // whole song plus wrap
    run(30, 1'b1, 1'b0, 2);   // random backpressure
    run(1, 1'b0, 1'b0, 1);    // drop play mid-note
    run(25, 1'b1, 1'b0, 1);   // restart from address 0
    run(2, 1'b1, 1'b1, 1);    // reset during PLAY
    run(25, 1'b1, 1'b0, 2);
    run(5, 1'b0, 1'b0, 1);
    repeat (2) @(negedge clk);
    check("queue_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lobby_melody_player.md
# lobby_melody_player

Melody sequencer and square-wave tone generator that produces the lobby-music samples written into the audio controller's output FIFO. It steps through a note ROM at a fixed beat rate and converts each entry, a half-period in clock cycles, into a ±AMPLITUDE square wave. It drives the controller's write handshake directly: it sits upstream of the codec path, in place of the free-running snd/delay logic.

## Interface
- BEAT_CYCLES, 2500000: PLAY-state cycles per note (50 ms at 50 MHz).
- SONG_LEN, 1000: number of ROM entries; the address wraps after SONG_LEN-1.
- ADDR_W, 10: ROM address width.
- HP_W, 19: half-period width.
- AMPLITUDE, 10000000: sample magnitude (signed 32-bit).
- CLOCK_50  in  1: sole clock.
- reset  in  1: synchronous, active-high.
- play  in  1: level; 1 = run the melody (lobby_sound).
- rom_addr  out  ADDR_W: note ROM address.
- rom_data  in  HP_W: half-period in CLOCK_50 cycles; 0 = rest. Valid one cycle after rom_addr (synchronous ROM).
- audio_out_allowed  in  1: controller FIFO has space.
- write_audio_out  out  1: write strobe to the controller.
- left_sample  out  32: signed sample, two's complement.
- right_sample  out  32: identical to left_sample.
- playing  out  1: high in PLAY.
- song_done  out  1: one-cycle pulse on address wrap.

## Operation
- States: IDLE, FETCH, WAIT, PLAY.
- IDLE: addr=0, beat=0, samples=0, write=0. On play=1, go to FETCH.
- FETCH: rom_addr is presented and already holds the current address. Next state is WAIT.
- WAIT: latch rom_data into half_period, clear the tone counter, set phase=1 (positive). Next state is PLAY.
- PLAY:
  - beat counts 0..BEAT_CYCLES-1.
  - At beat==BEAT_CYCLES-1: beat<=0; addr<=(addr==SONG_LEN-1)?0:addr+1; song_done=1 on wrap; next state is FETCH.
- Tone, active in PLAY only:
  - tone counter counts 0..half_period-1; at the terminal count it clears and phase toggles.
  - half_period==1 toggles every cycle.
  - half_period==0 (rest): counter frozen, sample = 0.
- Sample (registered, updated every PLAY cycle):
  - phase ? +AMPLITUDE : -AMPLITUDE.
  - 0 when resting or outside PLAY.
  - left_sample == right_sample always.
- write_audio_out = audio_out_allowed & (state==PLAY), combinational. The FIFO's backpressure alone paces consumption; the block never stalls on audio_out_allowed.
- play=0 in any state: next cycle IDLE, addr=0, beat=0, phase=0, samples=0. This is identical to reset.
- A beat terminal and a tone terminal in the same cycle: the beat transition wins. FETCH/WAIT reinitialise the tone state anyway.

## Timing
- Reset values:
  - rom_addr=0
  - write_audio_out=0
  - left_sample=right_sample=0
  - playing=0
  - song_done=0
  - state=IDLE
- Latency:
  - play rising edge to first PLAY cycle: 3 cycles (IDLE→FETCH→WAIT→PLAY).
  - First valid non-zero sample appears one cycle after entering PLAY.
- Note period: BEAT_CYCLES + 2 cycles (PLAY + FETCH + WAIT).
- song_done asserts in the cycle the address register loads 0 from SONG_LEN-1.
- reset takes priority over play.
- Reset asserted mid-note: all state clears at the next edge. Playback restarts at address 0.

## Structure
- Package lobby_audio_pkg holds:
  - state enum {IDLE, FETCH, WAIT, PLAY}
  - AMPLITUDE constant
  - HP_W and ADDR_W widths
  - BEAT_CYCLES default
- Sub-module square_osc holds:
  - inputs: clk, clear, enable, half_period
  - outputs: phase, rest
  - the tone counter and phase flop
- Sequencer FSM, beat counter and sample register stay in the top level.
- The ROM is external, so the contents can change without touching this block.

## Test plan
All runs use BEAT_CYCLES=8 and SONG_LEN=4.
- ROM={3,0,1,5}, play=1, audio_out_allowed=1:
  - rom_addr sequence 0,1,2,3,0.
  - Each address is held 10 cycles.
  - song_done pulses exactly once, on the 3→0 load.
- Note half_period=3:
  - sample sequence +A,+A,+A,-A,-A,-A,... within the 8 PLAY cycles.
  - At each note start, phase begins positive.
- Rest entry (0): samples are 0 for the whole note; write_audio_out still follows audio_out_allowed.
- audio_out_allowed toggled randomly: write_audio_out == allowed & playing in every cycle; beat timing is unaffected.
- Deassert play mid-note: next cycle IDLE, samples=0, rom_addr=0. Reasserting play restarts from address 0 after 3 cycles.
- Assert reset during PLAY with play=1: all outputs return to their reset values. Playback restarts once reset falls.
